// File: rtl/mem_copy_dma_if.sv
// Bus bundle between the copy/fill engine and its surroundings: the
// request/argument lines from the CPU side, the busy/done status, and the
// single-port 8-bit memory strobes, address and data.
interface mem_copy_dma_if;
  logic       start;
  logic       mode;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic [7:0] pattern;
  logic [7:0] memdata;
  logic       memread;
  logic       memwrite;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       busy;
  logic       done;

  // Engine side: takes the request and read data, drives the memory port.
  modport master (
    input  start, mode, src, dst, len, pattern, memdata,
    output memread, memwrite, adr, writedata, busy, done
  );

  // Requester/memory side: the mirror image of the engine.
  modport slave (
    output start, mode, src, dst, len, pattern, memdata,
    input  memread, memwrite, adr, writedata, busy, done
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Block copy / block fill engine for the 8-bit single-port memory.
// Copy alternates READ and WRITE one byte at a time; fill streams WRITEs.
// Overlapping copies whose destination lies above the source run downwards
// so no source byte is overwritten before it has been read.
module mem_copy_dma (
  input  logic           clk,
  input  logic           reset,
  mem_copy_dma_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t     state_q, state_d;
  logic       mode_q;
  logic       desc_q;
  logic [7:0] pat_q;
  logic [7:0] cnt_q;
  logic [7:0] rp_q;
  logic [7:0] wp_q;

  logic       memread_c;
  logic       memwrite_c;
  logic [7:0] adr_c;
  logic [7:0] wdata_c;
  logic       busy_c;
  logic       done_c;

  // Direction decision and end-of-block offsets, evaluated on the request
  // inputs so they can be captured together with start.
  logic [8:0] src_end;
  logic [7:0] last_off;
  logic       desc_w;

  assign src_end  = {1'b0, bus.src} + {1'b0, bus.len};
  assign last_off = bus.len - 8'd1;
  assign desc_w   = !bus.mode && (bus.dst > bus.src) && ({1'b0, bus.dst} < src_end);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Argument capture, pointer stepping and byte counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
      desc_q <= 1'b0;
      pat_q  <= '0;
      cnt_q  <= '0;
      rp_q   <= '0;
      wp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            desc_q <= desc_w;
            pat_q  <= bus.pattern;
            cnt_q  <= bus.len;
            rp_q   <= desc_w ? bus.src + last_off : bus.src;
            wp_q   <= desc_w ? bus.dst + last_off : bus.dst;
          end
        end
        READ: begin
          rp_q <= desc_q ? rp_q - 8'd1 : rp_q + 8'd1;
        end
        WRITE: begin
          wp_q  <= desc_q ? wp_q - 8'd1 : wp_q + 8'd1;
          cnt_q <= cnt_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and Moore outputs; in copy mode the write data is the byte
  // the memory returns for the preceding READ.
  always_comb begin
    state_d    = state_q;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    adr_c      = '0;
    wdata_c    = '0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == 8'd0) state_d = DONE;
          else if (bus.mode)   state_d = WRITE;
          else                 state_d = READ;
        end
      end
      READ: begin
        memread_c = 1'b1;
        adr_c     = rp_q;
        busy_c    = 1'b1;
        state_d   = WRITE;
      end
      WRITE: begin
        memwrite_c = 1'b1;
        adr_c      = wp_q;
        wdata_c    = mode_q ? pat_q : bus.memdata;
        busy_c     = 1'b1;
        if (cnt_q == 8'd1) state_d = DONE;
        else if (mode_q)   state_d = WRITE;
        else               state_d = READ;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.memread   = memread_c;
  assign bus.memwrite  = memwrite_c;
  assign bus.adr       = adr_c;
  assign bus.writedata = wdata_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: a synchronous-read memory model, a byte-level
// reference of copy/fill producing the expected bus operations and final
// memory image, directed cases and randomized requests.
module tb_mem_copy_dma;

  logic clk = 1'b0;
  logic reset;

  mem_copy_dma_if bus ();

  mem_copy_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem      [256];
  logic [7:0] init_mem [256];
  logic       load = 1'b0;

  // Memory: whole-image preload, byte write, read data one cycle later.
  always @(posedge clk) begin
    if (load) mem <= init_mem;
    else if (bus.memwrite) mem[bus.adr] <= bus.writedata;
    bus.memdata <= mem[bus.adr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus protocol: never both strobes, and no strobe outside READ/WRITE.
  always @(negedge clk) begin
    check("rw_exclusive", 32'(bus.memread & bus.memwrite), 32'd0);
    check("strobe_not_busy", 32'((bus.memread | bus.memwrite) & ~bus.busy), 32'd0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int pk(int kind, int a, int d);
    return kind * 65536 + a * 256 + d;
  endfunction

  task automatic randomize_init();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
  endtask

  task automatic load_mem();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic scramble_inputs();
    bus.mode    = 1'($urandom);
    bus.src     = 8'($urandom);
    bus.dst     = 8'($urandom);
    bus.len     = 8'($urandom);
    bus.pattern = 8'($urandom);
  endtask

  // One request from start to done: model, drive, observe, compare.
  task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] l, input logic [7:0] p, input bit disturb);
    logic [7:0] ref_mem [256];
    int eops[$];
    int oops[$];
    logic [7:0] off, r, w;
    logic desc;
    int exp_busy, bc, done_k, nm;

    load_mem();
    ref_mem = init_mem;
    desc = !m && (d > s) && (int'(d) < int'(s) + int'(l));
    for (int i = 0; i < int'(l); i++) begin
      off = desc ? 8'(int'(l) - 1 - i) : 8'(i);
      w = d + off;
      if (m) begin
        eops.push_back(pk(2, int'(w), int'(p)));
        ref_mem[w] = p;
      end else begin
        r = s + off;
        eops.push_back(pk(1, int'(r), 0));
        eops.push_back(pk(2, int'(w), int'(ref_mem[r])));
        ref_mem[w] = ref_mem[r];
      end
    end
    exp_busy = m ? int'(l) : 2 * int'(l);

    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.src = s; bus.dst = d; bus.len = l; bus.pattern = p;
    bc = 0; done_k = 0;
    for (int k = 1; k <= 600 && done_k == 0; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      scramble_inputs();
      if (disturb && k == 2) bus.start = 1'b1;
      if (bus.memread)  oops.push_back(pk(1, int'(bus.adr), 0));
      if (bus.memwrite) oops.push_back(pk(2, int'(bus.adr), int'(bus.writedata)));
      if (bus.busy) bc++;
      if (bus.done) done_k = k;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(done_k != 0), 32'd1);
    check("done_latency", 32'(done_k), 32'(exp_busy + 1));
    check("busy_cycles", 32'(bc), 32'(exp_busy));
    check("op_count", 32'(oops.size()), 32'(eops.size()));
    for (int i = 0; i < eops.size() && i < oops.size(); i++)
      check($sformatf("op%0d", i), 32'(oops[i]), 32'(eops[i]));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    nm = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nm++;
    check("mem_image", 32'(nm), 32'd0);
  endtask

  task automatic reset_mid_copy();
    int wcount;
    randomize_init();
    load_mem();
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.src = 8'h10; bus.dst = 8'h60; bus.len = 8'd5;
    bus.pattern = 8'h00;
    wcount = 0;
    for (int k = 0; k < 20 && wcount < 2; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.memwrite) wcount++;
      check("rst_no_done_before", 32'(bus.done), 32'd0);
    end
    check("rst_reached_2nd_write", 32'(wcount), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_outputs", {18'd0, bus.memread, bus.memwrite, bus.busy, bus.done,
                          bus.adr, bus.writedata}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rst_no_done", 32'(bus.done | bus.busy), 32'd0);
    end
    check("rst_byte0", 32'(mem[8'h60]), 32'(init_mem[8'h10]));
    check("rst_byte2", 32'(mem[8'h62]), 32'(init_mem[8'h62]));
    check("rst_byte3", 32'(mem[8'h63]), 32'(init_mem[8'h63]));
    check("rst_byte4", 32'(mem[8'h64]), 32'(init_mem[8'h64]));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    bus.pattern = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {18'd0, bus.memread, bus.memwrite, bus.busy, bus.done,
                            bus.adr, bus.writedata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", {18'd0, bus.memread, bus.memwrite, bus.busy, bus.done,
                           bus.adr, bus.writedata}, 32'd0);

    // Ascending copy.
    randomize_init();
    init_mem[8'h10] = 8'hAA; init_mem[8'h11] = 8'hBB; init_mem[8'h12] = 8'hCC;
    run_op(1'b0, 8'h10, 8'h40, 8'd3, 8'h00, 1'b0);
    check("asc_40", 32'(mem[8'h40]), 32'hAA);
    check("asc_41", 32'(mem[8'h41]), 32'hBB);
    check("asc_42", 32'(mem[8'h42]), 32'hCC);

    // Overlapping copy, destination above source.
    randomize_init();
    init_mem[8'h20] = 8'h01; init_mem[8'h21] = 8'h02;
    init_mem[8'h22] = 8'h03; init_mem[8'h23] = 8'h04;
    run_op(1'b0, 8'h20, 8'h22, 8'd4, 8'h00, 1'b0);
    check("ovl_22", 32'(mem[8'h22]), 32'h01);
    check("ovl_23", 32'(mem[8'h23]), 32'h02);
    check("ovl_24", 32'(mem[8'h24]), 32'h03);
    check("ovl_25", 32'(mem[8'h25]), 32'h04);

    // Fill wrapping past 0xFF.
    randomize_init();
    run_op(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, 1'b0);
    check("fill_fe", 32'(mem[8'hFE]), 32'h5A);
    check("fill_01", 32'(mem[8'h01]), 32'h5A);

    // Zero length, then a copy with a stray start in the middle.
    randomize_init();
    run_op(1'b0, 8'h33, 8'h44, 8'd0, 8'h00, 1'b0);
    randomize_init();
    run_op(1'b0, 8'h50, 8'h90, 8'd3, 8'h00, 1'b1);

    reset_mid_copy();
    randomize_init();
    run_op(1'b0, 8'h10, 8'h60, 8'd5, 8'h00, 1'b0);

    // Randomized requests, including wrap-around and overlap cases.
    for (int t = 0; t < 20; t++) begin
      logic [7:0] rs, rd, rl;
      rs = 8'($urandom);
      rd = ($urandom_range(0, 1) == 1) ? rs + 8'($urandom_range(0, 12)) : 8'($urandom);
      rl = 8'($urandom_range(0, 40));
      randomize_init();
      run_op(1'($urandom), rs, rd, rl, 8'($urandom), 1'($urandom));
    end
    randomize_init();
    run_op(1'b0, 8'h80, 8'h81, 8'd255, 8'h00, 1'b0);
    randomize_init();
    run_op(1'b1, 8'h00, 8'h07, 8'd255, 8'hC3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
